// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding,
// CTRL field positions and the CLAIM read-word builder.
package irq_ctrl_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  localparam logic [1:0] REG_PEND  = 2'd2;
  localparam logic [1:0] REG_CLAIM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SVC  = 2'b10
  } state_e;

  localparam int CTRL_GEN      = 0;
  localparam int CTRL_EDGE_LSB = 8;

  // CLAIM word: valid flag in bit 31, source id in the low three bits.
  function automatic logic [31:0] claim_word(input logic valid, input logic [2:0] id);
    return {valid, 28'd0, id};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req (index 0 wins).
module irq_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [2:0]      id
);

  // Scan from the top so the lowest active index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      valid = valid | req[i];
      id    = req[i] ? 3'(i) : id;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches edge/level sources, masks them,
// and presents one request at a time to the CPU with an ack/EOI handshake.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] irq_src,
  input  logic            int_ack,
  output logic            IRQ,
  output logic [2:0]      irq_id
);

  logic            gen_r;
  logic [NSRC-1:0] edge_r;
  logic [NSRC-1:0] mask_r;
  logic [NSRC-1:0] pend_r;
  logic [NSRC-1:0] prev_r;
  state_e          state_r;
  state_e          state_next_s;
  logic            irq_r;
  logic            irq_next_s;
  logic [2:0]      cur_id_r;
  logic [2:0]      cur_id_next_s;

  logic [1:0]      reg_sel_s;
  logic            wr_ctrl_s;
  logic            wr_mask_s;
  logic            wr_pend_s;
  logic            eoi_s;
  logic            gen_eff_s;
  logic [NSRC-1:0] mask_eff_s;
  logic [NSRC-1:0] w1c_s;
  logic [NSRC-1:0] active_s;
  logic [NSRC-1:0] ack_clr_s;
  logic [NSRC-1:0] pend_next_s;
  logic            sel_valid_s;
  logic [2:0]      sel_id_s;
  logic            cur_active_s;
  logic [31:0]     rdata_s;
  logic            unused_s;

  assign reg_sel_s = Addr[3:2];
  assign wr_ctrl_s = WE && (reg_sel_s == REG_CTRL);
  assign wr_mask_s = WE && (reg_sel_s == REG_MASK);
  assign wr_pend_s = WE && (reg_sel_s == REG_PEND);
  assign eoi_s     = WE && (reg_sel_s == REG_CLAIM);
  assign unused_s  = ^{Addr[31:4], Addr[1:0], Din};

  // A write in this cycle already steers this cycle's FSM decision.
  assign gen_eff_s  = wr_ctrl_s ? Din[CTRL_GEN] : gen_r;
  assign mask_eff_s = wr_mask_s ? Din[NSRC-1:0] : mask_r;
  assign w1c_s      = wr_pend_s ? Din[NSRC-1:0] : {NSRC{1'b0}};
  assign active_s   = pend_r & ~w1c_s & mask_eff_s;

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .req   (active_s),
    .valid (sel_valid_s),
    .id    (sel_id_s)
  );

  // Per-source view of the frozen id: still active, and pending clear on ack.
  always_comb begin
    cur_active_s = 1'b0;
    ack_clr_s    = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      cur_active_s = cur_active_s | (active_s[i] && (cur_id_r == 3'(i)));
      ack_clr_s[i] = (state_r == ST_REQ) && (state_next_s == ST_SVC) && (cur_id_r == 3'(i));
    end
  end

  // Edge bits hold until W1C/ack (a new edge wins); level bits mirror the line.
  assign pend_next_s = (edge_r & ((pend_r & ~w1c_s & ~ack_clr_s) | (irq_src & ~prev_r)))
                     | (~edge_r & irq_src);

  // Configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen_r  <= 1'b0;
      edge_r <= {NSRC{1'b0}};
      mask_r <= {NSRC{1'b0}};
    end else begin
      if (wr_ctrl_s) begin
        gen_r  <= Din[CTRL_GEN];
        edge_r <= Din[CTRL_EDGE_LSB +: NSRC];
      end
      if (wr_mask_s) begin
        mask_r <= Din[NSRC-1:0];
      end
    end
  end

  // Pending latch and previous-sample register for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= {NSRC{1'b0}};
      prev_r <= {NSRC{1'b0}};
    end else begin
      pend_r <= pend_next_s;
      prev_r <= irq_src;
    end
  end

  // FSM state plus the registered request and id outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      irq_r    <= 1'b0;
      cur_id_r <= 3'd0;
    end else begin
      state_r  <= state_next_s;
      irq_r    <= irq_next_s;
      cur_id_r <= cur_id_next_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: state_next_s = (gen_eff_s && sel_valid_s) ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (!gen_eff_s || !cur_active_s) begin
          state_next_s = ST_IDLE;
        end else if (int_ack) begin
          state_next_s = ST_SVC;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_SVC:  state_next_s = eoi_s ? ST_IDLE : ST_SVC;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: IRQ tracks REQ; the id is captured only on entry to REQ.
  always_comb begin
    irq_next_s    = (state_next_s == ST_REQ);
    cur_id_next_s = ((state_r == ST_IDLE) && (state_next_s == ST_REQ)) ? sel_id_s : cur_id_r;
  end

  // Register read mux.
  always_comb begin
    rdata_s = 32'd0;
    case (reg_sel_s)
      REG_CTRL: begin
        rdata_s[CTRL_GEN]                = gen_r;
        rdata_s[CTRL_EDGE_LSB +: NSRC]   = edge_r;
      end
      REG_MASK:  rdata_s[NSRC-1:0] = mask_r;
      REG_PEND:  rdata_s[NSRC-1:0] = pend_r;
      REG_CLAIM: rdata_s = claim_word(state_r != ST_IDLE, cur_id_r);
      default:   rdata_s = 32'd0;
    endcase
  end

  assign Dout   = rdata_s;
  assign IRQ    = irq_r;
  assign irq_id = cur_id_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected reads and request ids,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_irq_ctrl;

  localparam int NSRC = 4;
  localparam logic [31:0] A_CTRL  = 32'h0;
  localparam logic [31:0] A_MASK  = 32'h4;
  localparam logic [31:0] A_PEND  = 32'h8;
  localparam logic [31:0] A_CLAIM = 32'hC;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [31:0]     Addr = 32'd0;
  logic            WE = 1'b0;
  logic [31:0]     Din = 32'd0;
  logic [31:0]     Dout;
  logic [NSRC-1:0] irq_src = '0;
  logic            int_ack = 1'b0;
  logic            IRQ;
  logic [2:0]      irq_id;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        irq;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      irq_q[$];
  rd_exp_t mon_e;
  int      mon_id;
  logic    rd_stb = 1'b0;
  logic    irq_prev = 1'b0;
  int      n_checks = 0;
  int      n_pass = 0;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq_src (irq_src),
    .int_ack (int_ack),
    .IRQ     (IRQ),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a; Din = d; WE = 1'b1;
    tick();
    WE = 1'b0; Din = 32'd0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp_d,
                        input logic exp_irq);
    rd_exp_t e;
    e.name = nm; e.dout = exp_d; e.irq = exp_irq;
    rd_q.push_back(e);
    Addr = a; rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  // Monitor: register reads on strobe, request ids on every IRQ rising edge.
  always @(negedge clk) begin
    if (rd_stb) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        $display("FAIL rd_underflow: read strobe with no expected entry");
      end else begin
        mon_e = rd_q.pop_front();
        if (Dout !== mon_e.dout || IRQ !== mon_e.irq)
          $display("FAIL %s: got Dout=%h IRQ=%b, expected Dout=%h IRQ=%b",
                   mon_e.name, Dout, IRQ, mon_e.dout, mon_e.irq);
        else
          n_pass++;
      end
    end
    if (IRQ === 1'b1 && irq_prev === 1'b0) begin
      n_checks++;
      if (irq_q.size() == 0) begin
        $display("FAIL irq_unexpected: IRQ rose with irq_id=%0d, none expected", irq_id);
      end else begin
        mon_id = irq_q.pop_front();
        if (irq_id !== 3'(mon_id))
          $display("FAIL irq_id: got %0d, expected %0d", irq_id, mon_id);
        else
          n_pass++;
      end
    end
    irq_prev = IRQ;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    tick(2);
    reset = 1'b1;
    rd_chk("rst_ctrl",  A_CTRL,  32'h0, 1'b0);
    rd_chk("rst_mask",  A_MASK,  32'h0, 1'b0);
    rd_chk("rst_pend",  A_PEND,  32'h0, 1'b0);
    rd_chk("rst_claim", A_CLAIM, 32'h0, 1'b0);

    // Edge source 0: pulse, request, ack, EOI.
    wr(A_CTRL, 32'h0000_0101);
    wr(A_MASK, 32'h1);
    rd_chk("ctrl_rb", A_CTRL, 32'h0000_0101, 1'b0);
    irq_q.push_back(0);
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    rd_chk("e_pend_set",  A_PEND,  32'h1, 1'b0);
    rd_chk("e_claim_req", A_CLAIM, 32'h8000_0000, 1'b1);
    ack_pulse();
    rd_chk("e_pend_ack",  A_PEND,  32'h0, 1'b0);
    rd_chk("e_claim_svc", A_CLAIM, 32'h8000_0000, 1'b0);
    wr(A_CLAIM, 32'h0);
    rd_chk("e_claim_eoi", A_CLAIM, 32'h0, 1'b0);
    tick(3);
    rd_chk("e_no_rereq",  A_CLAIM, 32'h0, 1'b0);

    // Level sources 1 and 3 held high.
    wr(A_CTRL, 32'h1);
    wr(A_MASK, 32'hA);
    irq_q.push_back(1);
    irq_src = 4'b1010; tick();
    rd_chk("l_idle",     A_CLAIM, 32'h0, 1'b0);
    rd_chk("l_req1",     A_CLAIM, 32'h8000_0001, 1'b1);
    ack_pulse();
    rd_chk("l_svc1",     A_CLAIM, 32'h8000_0001, 1'b0);
    irq_q.push_back(1);
    wr(A_CLAIM, 32'h0);
    rd_chk("l_eoi_idle", A_CLAIM, 32'h1, 1'b0);
    rd_chk("l_rereq1",   A_CLAIM, 32'h8000_0001, 1'b1);
    ack_pulse();
    irq_src = 4'b1000;
    irq_q.push_back(3);
    wr(A_CLAIM, 32'h0);
    rd_chk("l_eoi2",     A_CLAIM, 32'h1, 1'b0);
    rd_chk("l_req3",     A_CLAIM, 32'h8000_0003, 1'b1);
    ack_pulse();
    irq_src = 4'b0000;
    wr(A_CLAIM, 32'h0);
    rd_chk("l_pend_clr", A_PEND,  32'h0, 1'b0);
    rd_chk("l_idle3",    A_CLAIM, 32'h3, 1'b0);

    // Mask removed while in REQ, then restored.
    wr(A_MASK, 32'h4);
    irq_q.push_back(2);
    irq_src = 4'b0100; tick();
    rd_chk("m_idle",    A_CLAIM, 32'h3, 1'b0);
    rd_chk("m_req2",    A_CLAIM, 32'h8000_0002, 1'b1);
    wr(A_MASK, 32'h0);
    rd_chk("m_dropped", A_CLAIM, 32'h2, 1'b0);
    irq_q.push_back(2);
    wr(A_MASK, 32'h4);
    rd_chk("m_return",  A_CLAIM, 32'h8000_0002, 1'b1);
    ack_pulse();
    irq_src = 4'b0000;
    wr(A_CLAIM, 32'h0);
    rd_chk("m_idle2",   A_CLAIM, 32'h2, 1'b0);

    // Same-cycle edge and W1C on bit 0: set wins (source masked).
    wr(A_CTRL, 32'h0000_0101);
    wr(A_MASK, 32'h0);
    Addr = A_PEND; Din = 32'h1; WE = 1'b1; irq_src = 4'b0001;
    tick();
    WE = 1'b0; Din = 32'd0; irq_src = 4'b0000;
    rd_chk("w1c_setwins", A_PEND, 32'h1, 1'b0);
    wr(A_PEND, 32'h1);
    rd_chk("w1c_clear",   A_PEND, 32'h0, 1'b0);

    // Edge arriving in SVC waits for EOI; acks in IDLE are ignored.
    wr(A_MASK, 32'h1);
    irq_q.push_back(0);
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    tick();
    rd_chk("s_req0",     A_CLAIM, 32'h8000_0000, 1'b1);
    ack_pulse();
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    tick(3);
    rd_chk("s_hold_svc", A_CLAIM, 32'h8000_0000, 1'b0);
    rd_chk("s_pend",     A_PEND,  32'h1, 1'b0);
    irq_q.push_back(0);
    wr(A_CLAIM, 32'h0);
    rd_chk("s_eoi_idle", A_CLAIM, 32'h0, 1'b0);
    rd_chk("s_req_next", A_CLAIM, 32'h8000_0000, 1'b1);
    ack_pulse();
    wr(A_CLAIM, 32'h0);
    ack_pulse();
    ack_pulse();
    rd_chk("s_ack_idle", A_CLAIM, 32'h0, 1'b0);
    rd_chk("s_pend0",    A_PEND,  32'h0, 1'b0);

    // Reset asserted while a request is presented.
    irq_q.push_back(0);
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    tick();
    rd_chk("r_req",    A_CLAIM, 32'h8000_0000, 1'b1);
    reset = 1'b0;
    rd_chk("r_claim",  A_CLAIM, 32'h0, 1'b0);
    rd_chk("r_pend",   A_PEND,  32'h0, 1'b0);
    rd_chk("r_mask",   A_MASK,  32'h0, 1'b0);
    reset = 1'b1;
    rd_chk("r_ctrl",   A_CTRL,  32'h0, 1'b0);

    tick(3);
    n_checks++;
    if (rd_q.size() != 0 || irq_q.size() != 0)
      $display("FAIL leftover: %0d reads and %0d request ids never observed, expected 0",
               rd_q.size(), irq_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
